spi_slave_core: RTL
===================

Name: spi_slave_core

Overview:
- Single-lane SPI target (responder) peripheral: the counterpart of the SoC's SPI master; lets an external SPI master exchange bytes with the CPU.
- Oversamples external SCK/SS/MOSI in the clk_i domain, deserialises MOSI into an RX FIFO and serialises a TX FIFO onto MISO.
- Register interface matches the existing spi_core register port, so an OBI wrapper identical in style to the SPI master's wraps it unchanged.

Parameters:
- FIFO_DEPTH, 4, entries in each of the RX and TX FIFOs; power of two, ≥2.
- TX_IDLE, 8'hFF, byte shifted out when the TX FIFO is empty at a byte start.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- spi_clk_i  in  1  external SCK; asynchronous.
- spi_ss_i  in  1  external chip select, active-low; asynchronous.
- spi_dq0_i  in  1  MOSI; asynchronous.
- spi_dq1_o  out  1  MISO data.
- spi_dq1_oe_o  out  1  MISO output enable.
- irq_o  out  1  level interrupt.
- reg_we_i  in  1  register write strobe.
- reg_re_i  in  1  register read strobe.
- reg_wdata_i  in  32  write data.
- reg_be_i  in  4  byte enables.
- reg_addr_i  in  32  byte offset; base already stripped.
- reg_rdata_o  out  32  read data, combinational from reg_addr_i.

Behaviour:
- Reset: all outputs 0; CTRL=0; FIFOs empty; sticky flags clear; bit_cnt=0.
- Registers (only reg_be_i[0] is used; writes with be[0]=0 are ignored):
  - 0x00 CTRL: [0] EN, [1] CPOL, [2] CPHA, [3] RX_IE, [4] TX_IE, [5] SS_IE, [6] FLUSH (write-1, self-clears next cycle, empties both FIFOs, always reads 0).
  - 0x04 STATUS: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] busy (SS active and EN), [5] RX_OVF, [6] TX_UDF, [7] SS_END. Bits 5–7 are sticky; write 1 to clear.
  - 0x08 TXDATA: write pushes wdata[7:0]; write when full is dropped. Reads return 0.
  - 0x0C RXDATA: read returns {24'h0, head} and pops on reg_re_i. Read when empty returns 0 with no pop.
  - Unmapped addresses read 0.
- Synchronisers: 2-flop on SCK, SS, MOSI. Edges are detected from the synced SCK vs. its previous value. Latency from a pin edge to a MISO update is ≤3 clk_i cycles. Supported SCK ≤ clk_i/8.
- Edge roles: leading = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. The other edge is the shift edge.
- RX path:
  - On each sample edge while SS is low and EN=1: rx_sr = {rx_sr[6:0], mosi}, bit_cnt++.
  - When bit_cnt wraps 7→0, the byte is pushed to the RX FIFO. If the FIFO is full, the byte is dropped and RX_OVF is set.
- TX path, MSB first, load = pop TX FIFO or use TX_IDLE (TX_UDF set if empty):
  - CPHA=0: load on the synced SS falling edge. Also load on a shift edge with bit_cnt==0 that is not the first edge of the selection. All other shift edges shift left.
  - CPHA=1: on a shift edge, load if bit_cnt==0, else shift.
  - spi_dq1_o = tx_sr[7].
- spi_dq1_oe_o = EN & synced SS low.
- SS rising (deselect) or EN cleared mid-byte:
  - Partial RX byte discarded; bit_cnt=0.
  - Already-loaded TX byte lost; no requeue.
  - SS_END set on every synced SS rising edge while EN=1.
- EN=0: SPI pins ignored, oe=0; FIFOs retain contents and remain register-accessible.
- FIFO boundaries:
  - Simultaneous push and pop in one cycle both take effect; count unchanged. This holds when full too: the pop frees the slot.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Simultaneous events:
  - A hardware sticky set wins over a W1C in the same cycle.
  - FLUSH in the same cycle as a push or pop: flush wins.
- irq_o (registered) = (RX_IE & !rx_empty) | (TX_IE & tx_empty) | (SS_IE & SS_END).

Decomposition:
- spi_slave_pkg holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - the edge-role enum {SAMPLE_LEAD, SAMPLE_TRAIL}.
- One sub-module, spi_slave_fifo (WIDTH, DEPTH), with push/pop/flush, full/empty and head outputs; instantiated twice.

Test Plan:
- Mode 0 (CTRL=0x01), TX preloaded 0xA5, master sends 0x3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1; RXDATA reads 0x3C; afterwards rx_empty=1 and tx_empty=1.
- Modes 1–3 (CTRL=0x03/0x05/0x07), 3-byte burst, TX 0x11,0x22,0x33, master sends 0xDE,0xAD,0xBE → master receives 0x11,0x22,0x33; RX FIFO holds 0xDE,0xAD,0xBE in order.
- Empty TX: master sends 2 bytes → MISO carries 0xFF,0xFF; STATUS[6]=1; writing 0x40 to STATUS clears it.
- Overflow, DEPTH=4: master sends 5 bytes with no reads → RX holds the first 4; RX_OVF=1; rx_full=1. A pop coinciding with the 5th push is accepted and keeps count=4 with no overflow.
- SS deasserted after 5 bits → nothing pushed; SS_END=1; irq_o=1 with SS_IE set. The next full byte is received correctly.
- Reset asserted mid-byte → outputs 0 within the same cycle, FIFOs empty, CTRL=0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI target peripheral.
// Register map, CTRL/STATUS bit positions and edge roles.
package spi_slave_pkg;

  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_0008;
  localparam logic [31:0] ADDR_RXDATA = 32'h0000_000C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CPOL  = 1;
  localparam int CTRL_CPHA  = 2;
  localparam int CTRL_RX_IE = 3;
  localparam int CTRL_TX_IE = 4;
  localparam int CTRL_SS_IE = 5;
  localparam int CTRL_FLUSH = 6;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_TX_UDF   = 6;
  localparam int ST_SS_END   = 7;

  typedef enum logic {
    SAMPLE_LEAD,
    SAMPLE_TRAIL
  } edge_role_e;

endpackage

// File: rtl/spi_slave_fifo.sv
// Small synchronous FIFO with flush; a push is accepted
// when full if a pop frees a slot in the same cycle.
module spi_slave_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI target: oversampled SCK/SS/MOSI, RX/TX byte FIFOs,
// register port compatible with the SPI master core.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  TX_IDLE    = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_clk_i,
  input  logic        spi_ss_i,
  input  logic        spi_dq0_i,
  output logic        spi_dq1_o,
  output logic        spi_dq1_oe_o,
  output logic        irq_o,
  input  logic        reg_we_i,
  input  logic        reg_re_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_be_i,
  input  logic [31:0] reg_addr_i,
  output logic [31:0] reg_rdata_o
);

  // [0],[1] synchroniser stages, [2] previous synced value
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic [2:0] sticky_q, sticky_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d;
  logic       irq_q, irq_d;

  logic       en, cpol, active, busy;
  edge_role_e role;
  logic       rise, fall, lead, trail;
  logic       sample_e, shift_e, ss_fall, ss_rise;
  logic       wr, wr_ctrl, wr_status, wr_tx, flush;
  logic       rx_pop, rx_push, rx_full, rx_empty;
  logic       tx_pop, tx_full, tx_empty, load;
  logic [7:0] rx_head, tx_head, rx_byte;
  logic [2:0] w1c;
  logic       unused_bits;

  assign unused_bits = ^{reg_be_i[3:1], reg_wdata_i[31:8]};

  assign sck_sync_d  = {sck_sync_q[1:0], spi_clk_i};
  assign ss_sync_d   = {ss_sync_q[1:0], spi_ss_i};
  assign mosi_sync_d = {mosi_sync_q[0], spi_dq0_i};

  assign en     = ctrl_q[CTRL_EN];
  assign cpol   = ctrl_q[CTRL_CPOL];
  assign role   = ctrl_q[CTRL_CPHA] ? SAMPLE_TRAIL : SAMPLE_LEAD;
  assign active = en & ~ss_sync_q[1];
  assign busy   = active;

  assign rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign fall  = ~sck_sync_q[1] & sck_sync_q[2];
  assign lead  = cpol ? fall : rise;
  assign trail = cpol ? rise : fall;

  assign sample_e = active & ((role == SAMPLE_LEAD) ? lead : trail);
  assign shift_e  = active & ((role == SAMPLE_LEAD) ? trail : lead);
  assign ss_fall  = en & ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise  = en & ss_sync_q[1] & ~ss_sync_q[2];

  assign wr        = reg_we_i & reg_be_i[0];
  assign wr_ctrl   = wr & (reg_addr_i == ADDR_CTRL);
  assign wr_status = wr & (reg_addr_i == ADDR_STATUS);
  assign wr_tx     = wr & (reg_addr_i == ADDR_TXDATA);
  assign flush     = wr_ctrl & reg_wdata_i[CTRL_FLUSH];
  assign rx_pop    = reg_re_i & (reg_addr_i == ADDR_RXDATA);
  assign w1c       = wr_status ? reg_wdata_i[7:5] : 3'b000;

  assign rx_byte = {rx_sr_q[6:0], mosi_sync_q[1]};
  assign rx_push = sample_e & (bit_cnt_q == 3'd7);

  // CPHA=0 preloads on select; the first edge is never a load
  assign load = (role == SAMPLE_LEAD)
              ? (ss_fall | (shift_e & (bit_cnt_q == 3'd0) & ~first_q))
              : (shift_e & (bit_cnt_q == 3'd0));
  assign tx_pop = load & ~tx_empty;

  always_comb begin
    ctrl_d    = ctrl_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    if (wr_ctrl) ctrl_d = reg_wdata_i[5:0];
    sticky_d = (sticky_q & ~w1c)
             | {ss_rise, load & tx_empty,
                rx_push & rx_full & ~rx_pop};
    if (!active) begin
      bit_cnt_d = 3'd0;
    end else if (sample_e) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (ss_fall)                    first_d = 1'b1;
    else if (active && (rise || fall)) first_d = 1'b0;
    if (load)         tx_sr_d = tx_empty ? TX_IDLE : tx_head;
    else if (shift_e) tx_sr_d = {tx_sr_q[6:0], 1'b0};
    irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty)
          | (ctrl_q[CTRL_TX_IE] & tx_empty)
          | (ctrl_q[CTRL_SS_IE] & sticky_q[2]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      ctrl_q      <= '0;
      sticky_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ctrl_q      <= ctrl_d;
      sticky_q    <= sticky_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      irq_q       <= irq_d;
    end
  end

  spi_slave_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (rx_push),
    .data_i  (rx_byte),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  spi_slave_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (wr_tx),
    .data_i  (reg_wdata_i[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  assign spi_dq1_o    = tx_sr_q[7];
  assign spi_dq1_oe_o = active;
  assign irq_o        = irq_q;

  always_comb begin
    reg_rdata_o = 32'h0;
    case (reg_addr_i)
      ADDR_CTRL:   reg_rdata_o = {26'h0, ctrl_q};
      ADDR_STATUS: reg_rdata_o = {24'h0, sticky_q, busy, tx_full,
                                  tx_empty, rx_full, rx_empty};
      ADDR_RXDATA: reg_rdata_o = rx_empty ? 32'h0 : {24'h0, rx_head};
      default:     reg_rdata_o = 32'h0;
    endcase
  end

endmodule
